orb_sincos_pipe: RTL and testbench
==================================

Name: orb_sincos_pipe

Overview:
- Pipelined, full-circle sine/cosine lookup for ORB keypoint orientation: angle-bin index in, signed sin/cos pair out.
- Parametrised successor of the combinational quarter-circle angle LUT. Adds 4-quadrant folding, selectable output width and rounding, a valid/ready handshake with backpressure, a pass-through tag and out-of-range detection.
- Sits between the orientation (intensity-centroid bin) stage and the rotated-BRIEF pattern-rotation stage.

Parameters:
- QUAD_BINS, 25: bins per quarter circle; full circle = 4*QUAD_BINS bins.
- IDX_W, 7: index width; must satisfy 2^IDX_W >= 4*QUAD_BINS.
- TABLE_W, 12: ROM word width, signed Q1.(TABLE_W-1); all entries positive.
- BW_OUT, 11: output width, signed; requires BW_OUT <= TABLE_W.
- ROUND, 0: 0 = truncate, 1 = round-half-up with saturation to +(2^(BW_OUT-1)-1).
- TAG_W, 8: sideband tag width.

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous active-high reset.
- in_valid  in  1  input index valid.
- in_ready  out  1  block accepts input this cycle.
- in_index  in  IDX_W  angle bin i; angle = (pi/2)*(i+0.5)/QUAD_BINS.
- in_tag  in  TAG_W  keypoint id, passed through unchanged.
- out_valid  out  1  result valid.
- out_ready  in  1  downstream accepts result.
- out_sin  out  BW_OUT  signed sin(angle).
- out_cos  out  BW_OUT  signed cos(angle).
- out_tag  out  TAG_W  tag aligned with the result.
- out_err  out  1  index >= 4*QUAD_BINS; sin and cos forced to 0.

Interface (already decided): one clock; reset is synchronous and active-high (clk, rst).

Behaviour:
- ROM T[k], k = 0..QUAD_BINS-1, holds sin((pi/2)(k+0.5)/QUAD_BINS) in TABLE_W-bit Q1.(TABLE_W-1). cos of the same bin = T[QUAD_BINS-1-k]. Defaults: T[0] = 0x040, T[6] = 0x32D, T[12] = 0x5A8, T[18] = 0x757, T[24] = 0x7FE.
- Stage 1 (decode):
  - q = quadrant and k = i - q*QUAD_BINS, from three parallel compares against QUAD_BINS, 2*QUAD_BINS and 3*QUAD_BINS. No divider.
  - err = (i >= 4*QUAD_BINS).
  - Registers q, k, kr = QUAD_BINS-1-k, err and tag.
- Stage 2 (lookup and sign):
  - a = T[k], b = T[kr]; reduce each to BW_OUT bits by arithmetic shift of TABLE_W-BW_OUT bits, truncated or rounded per ROUND.
  - Apply sign after reduction, so results are magnitude-symmetric.
  - q0: sin = +a, cos = +b. q1: sin = +b, cos = -a. q2: sin = -a, cos = -b. q3: sin = -b, cos = +a.
  - If err: sin = cos = 0, out_err = 1.
  - Outputs are registered.
- Latency: 2 cycles from the accepting edge to out_valid. Throughput: 1 result per cycle.
- Handshake:
  - Transfer occurs on in_valid && in_ready, or on out_valid && out_ready.
  - A stage advances when it is empty or its downstream stage advances.
  - in_ready = !s1_valid || s2_advance; it is combinational from out_ready, with no combinational path from in_valid.
  - While out_valid && !out_ready, out_sin, out_cos, out_tag and out_err hold stable.
  - Simultaneous accept and emit in one cycle is permitted. No bubbles at full rate. No data loss or duplication.
- Reset:
  - Clears s1_valid and out_valid; out_sin, out_cos, out_tag and out_err = 0; in_ready = 0 during the rst cycle.
  - In-flight data is discarded on reset mid-operation. in_ready = 1 on the first cycle after rst deasserts.
- Boundaries:
  - Index 4*QUAD_BINS-1 maps to q3, k = QUAD_BINS-1.
  - Indices 4*QUAD_BINS .. 2^IDX_W-1 give err.
  - Rounding of the maximum entry never overflows (saturates).

Decomposition:
- Package orb_trig_pkg: default QUAD_BINS/TABLE_W; the quarter-wave ROM contents as a constant array (generated offline, default set exactly as above); a quadrant enum Q0..Q3; a reduce_round function (shift, round, saturate).
- Sub-module orb_quarter_wave_rom: a dual combinational read port (k, kr) returning T[k] and T[kr]. It is instantiated once, in stage 2.

Test Plan:
- Reset, then index 0 with ROUND=0, out_ready=1 -> 2 cycles later out_valid=1, sin=32, cos=1023, out_err=0.
- Indices 25, 62, 99 back-to-back -> consecutive cycles (25 -> sin=1023, cos=-32); (62 -> sin=-724, cos=-724); (99 -> sin=-32, cos=1023); tags preserved in order.
- Index 6 under ROUND=0 -> sin=406, cos=939; the same index under ROUND=1 -> sin=407, cos=940.
- Index 100 and index 127 -> out_err=1, sin=cos=0; the neighbouring valid index 99 is unaffected.
- Stream all 100 indices with random in_valid and random out_ready stalls -> every result is produced exactly once, in order, outputs stable while stalled, matching a golden model.
- Assert rst with two items in flight -> out_valid=0 the next cycle, outputs zero, and no stale result appears after reset.

Source files
------------

// File: rtl/orb_trig_pkg.sv
// Shared constants, quadrant type, quarter-wave table and width-reduction helper
// for the ORB sin/cos pipeline.
package orb_trig_pkg;

    localparam int unsigned QUAD_BINS_DEF = 25;
    localparam int unsigned TABLE_W_DEF   = 12;

    typedef enum logic [1:0] {
        Q0 = 2'd0,
        Q1 = 2'd1,
        Q2 = 2'd2,
        Q3 = 2'd3
    } quad_e;

    // floor(2^(TABLE_W-1) * sin((pi/2)(k+0.5)/QUAD_BINS)), generated offline
    localparam int unsigned QW_ROM [QUAD_BINS_DEF] = '{
        64,   192,  320,  446,  571,  693,  813,  929,  1042, 1151, 1255, 1354, 1448,
        1536, 1618, 1693, 1762, 1824, 1879, 1926, 1966, 1998, 2022, 2038, 2046
    };

    // Drop sh LSBs of a positive value, optionally rounding half-up, clamped to the bw-bit signed max
    function automatic int unsigned reduce_round(input int unsigned val, input int unsigned sh,
                                                 input bit rnd, input int unsigned bw);
        int unsigned r;
        int unsigned max_v;
        max_v = (32'd1 << (bw - 32'd1)) - 32'd1;
        if (rnd && (sh != 32'd0)) begin
            r = (val + (32'd1 << (sh - 32'd1))) >> sh;
        end else begin
            r = val >> sh;
        end
        if (r > max_v) begin
            r = max_v;
        end
        return r;
    endfunction

endpackage

// File: rtl/orb_quarter_wave_rom.sv
// Dual combinational read port into the quarter-wave sine table: T[k] and T[kr].
module orb_quarter_wave_rom
    import orb_trig_pkg::*;
#(
    parameter int unsigned QUAD_BINS = QUAD_BINS_DEF,
    parameter int unsigned TABLE_W   = TABLE_W_DEF,
    parameter int unsigned KW        = $clog2(QUAD_BINS)
) (
    input  logic [KW-1:0]      k,
    input  logic [KW-1:0]      kr,
    output logic [TABLE_W-1:0] a_c,
    output logic [TABLE_W-1:0] b_c
);

    assign a_c = TABLE_W'(QW_ROM[k]);
    assign b_c = TABLE_W'(QW_ROM[kr]);

endmodule

// File: rtl/orb_sincos_pipe.sv
// Two-stage full-circle sin/cos lookup with quadrant folding, valid/ready backpressure,
// tag pass-through and out-of-range flagging.
module orb_sincos_pipe
    import orb_trig_pkg::*;
#(
    parameter int unsigned QUAD_BINS = QUAD_BINS_DEF,
    parameter int unsigned IDX_W     = 7,
    parameter int unsigned TABLE_W   = TABLE_W_DEF,
    parameter int unsigned BW_OUT    = 11,
    parameter bit          ROUND     = 1'b0,
    parameter int unsigned TAG_W     = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [IDX_W-1:0]  in_index,
    input  logic [TAG_W-1:0]  in_tag,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [BW_OUT-1:0] out_sin,
    output logic [BW_OUT-1:0] out_cos,
    output logic [TAG_W-1:0]  out_tag,
    output logic              out_err
);

    localparam int unsigned KW    = $clog2(QUAD_BINS);
    localparam int unsigned SHIFT = TABLE_W - BW_OUT;

    logic               s1_valid;
    quad_e              s1_q;
    logic [KW-1:0]      s1_k;
    logic [KW-1:0]      s1_kr;
    logic               s1_err;
    logic [TAG_W-1:0]   s1_tag;
    logic               s2_advance;

    quad_e              dec_q;
    logic [IDX_W-1:0]   dec_base;
    logic [KW-1:0]      dec_k;
    logic               dec_err;

    logic [TABLE_W-1:0] rom_a;
    logic [TABLE_W-1:0] rom_b;
    logic [BW_OUT-1:0]  mag_a;
    logic [BW_OUT-1:0]  mag_b;
    logic [BW_OUT-1:0]  sin_c;
    logic [BW_OUT-1:0]  cos_c;

    assign s2_advance = !out_valid || out_ready;
    assign in_ready   = !rst && (!s1_valid || s2_advance);

    // Quadrant fold from three parallel threshold compares; no divider
    always_comb begin
        dec_q    = Q0;
        dec_base = '0;
        dec_err  = (in_index >= IDX_W'(4 * QUAD_BINS));
        if (in_index >= IDX_W'(3 * QUAD_BINS)) begin
            dec_q    = Q3;
            dec_base = IDX_W'(3 * QUAD_BINS);
        end else if (in_index >= IDX_W'(2 * QUAD_BINS)) begin
            dec_q    = Q2;
            dec_base = IDX_W'(2 * QUAD_BINS);
        end else if (in_index >= IDX_W'(QUAD_BINS)) begin
            dec_q    = Q1;
            dec_base = IDX_W'(QUAD_BINS);
        end
        dec_k = dec_err ? '0 : KW'(in_index - dec_base);
    end

    orb_quarter_wave_rom #(
        .QUAD_BINS (QUAD_BINS),
        .TABLE_W   (TABLE_W),
        .KW        (KW)
    ) u_rom (
        .k   (s1_k),
        .kr  (s1_kr),
        .a_c (rom_a),
        .b_c (rom_b)
    );

    assign mag_a = BW_OUT'(reduce_round(32'(rom_a), SHIFT, ROUND, BW_OUT));
    assign mag_b = BW_OUT'(reduce_round(32'(rom_b), SHIFT, ROUND, BW_OUT));

    // Sign applied after reduction so every quadrant sees identical magnitudes
    always_comb begin
        sin_c = '0;
        cos_c = '0;
        if (!s1_err) begin
            case (s1_q)
                Q0: begin sin_c = mag_a;  cos_c = mag_b;  end
                Q1: begin sin_c = mag_b;  cos_c = -mag_a; end
                Q2: begin sin_c = -mag_a; cos_c = -mag_b; end
                Q3: begin sin_c = -mag_b; cos_c = mag_a;  end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            s1_valid  <= 1'b0;
            s1_q      <= Q0;
            s1_k      <= '0;
            s1_kr     <= '0;
            s1_err    <= 1'b0;
            s1_tag    <= '0;
            out_valid <= 1'b0;
            out_sin   <= '0;
            out_cos   <= '0;
            out_tag   <= '0;
            out_err   <= 1'b0;
        end else begin
            if (in_ready) begin
                s1_valid <= in_valid;
                if (in_valid) begin
                    s1_q   <= dec_q;
                    s1_k   <= dec_k;
                    s1_kr  <= KW'(QUAD_BINS - 1) - dec_k;
                    s1_err <= dec_err;
                    s1_tag <= in_tag;
                end
            end
            if (s2_advance) begin
                out_valid <= s1_valid;
                if (s1_valid) begin
                    out_sin <= sin_c;
                    out_cos <= cos_c;
                    out_tag <= s1_tag;
                    out_err <= s1_err;
                end
            end
        end
    end

endmodule

// File: tb/tb_orb_sincos_pipe.sv
// Bench for orb_sincos_pipe: truncating and rounding instances in lockstep, checked
// against a real-arithmetic sin/cos model through an in-order scoreboard.
module tb_orb_sincos_pipe;

    localparam int unsigned IDX_W  = 7;
    localparam int unsigned TAG_W  = 8;
    localparam int unsigned BW_OUT = 11;
    localparam int          NBINS  = 100;
    localparam int          MAXMAG = 1023;
    localparam real         PI     = 3.14159265358979323846;

    logic              clk = 1'b0;
    logic              rst;
    logic              in_valid;
    logic              in_ready;
    logic              in_ready_r;
    logic [IDX_W-1:0]  in_index;
    logic [TAG_W-1:0]  in_tag;
    logic              out_ready;
    logic              out_valid;
    logic              out_valid_r;
    logic [BW_OUT-1:0] out_sin;
    logic [BW_OUT-1:0] out_cos;
    logic [BW_OUT-1:0] out_sin_r;
    logic [BW_OUT-1:0] out_cos_r;
    logic [TAG_W-1:0]  out_tag;
    logic [TAG_W-1:0]  out_tag_r;
    logic              out_err;
    logic              out_err_r;

    int total = 0;
    int bad   = 0;
    int or_mode = 0;

    typedef struct {
        int idx;
        int tag;
    } item_t;
    item_t sb[$];

    always #5 clk = ~clk;

    orb_sincos_pipe #(.ROUND(1'b0)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_index  (in_index),
        .in_tag    (in_tag),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_sin   (out_sin),
        .out_cos   (out_cos),
        .out_tag   (out_tag),
        .out_err   (out_err)
    );

    orb_sincos_pipe #(.ROUND(1'b1)) dut_r (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready_r),
        .in_index  (in_index),
        .in_tag    (in_tag),
        .out_valid (out_valid_r),
        .out_ready (out_ready),
        .out_sin   (out_sin_r),
        .out_cos   (out_cos_r),
        .out_tag   (out_tag_r),
        .out_err   (out_err_r)
    );

    task automatic check_eq(input string tag, input int got, input int exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
        end
    endtask

    // Q1.10 value of a real in [-1,1]: magnitude floored at 12 bits, then halved
    function automatic int scale(input real v, input bit rnd);
        real av;
        int  m;
        av = (v < 0.0) ? -v : v;
        m  = int'($floor(2048.0 * av));
        m  = rnd ? (m + 1) / 2 : m / 2;
        if (m > MAXMAG) m = MAXMAG;
        return (v < 0.0) ? -m : m;
    endfunction

    function automatic void model(input int idx, input bit rnd, output int s, output int c, output int e);
        real th;
        if (idx >= NBINS) begin
            s = 0;
            c = 0;
            e = 1;
        end else begin
            th = (PI / 2.0) * (real'(idx) + 0.5) / 25.0;
            s  = scale($sin(th), rnd);
            c  = scale($cos(th), rnd);
            e  = 0;
        end
    endfunction

    // Scoreboard: whatever is on the output, stalled or not, must be the oldest accepted item
    always @(negedge clk) begin
        int es, ec, ee, rs, rc, re;
        if (!rst) begin
            check_eq("r_valid", int'(out_valid_r), int'(out_valid));
            check_eq("r_ready", int'(in_ready_r), int'(in_ready));
            if (out_valid) begin
                if (sb.size() == 0) begin
                    check_eq("spurious_out", int'(out_valid), 0);
                end else begin
                    model(sb[0].idx, 1'b0, es, ec, ee);
                    model(sb[0].idx, 1'b1, rs, rc, re);
                    check_eq("sin",   int'($signed(out_sin)),   es);
                    check_eq("cos",   int'($signed(out_cos)),   ec);
                    check_eq("err",   int'(out_err),            ee);
                    check_eq("tag",   int'(out_tag),            sb[0].tag);
                    check_eq("sin_r", int'($signed(out_sin_r)), rs);
                    check_eq("cos_r", int'($signed(out_cos_r)), rc);
                    check_eq("err_r", int'(out_err_r),          re);
                    check_eq("tag_r", int'(out_tag_r),          sb[0].tag);
                    if (out_ready) void'(sb.pop_front());
                end
            end
            if (in_valid && in_ready) sb.push_back('{idx: int'(in_index), tag: int'(in_tag)});
        end
    end

    // Downstream: 0 = always ready, 1 = random stalls, 2 = fully stalled
    initial begin
        out_ready = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            case (or_mode)
                0:       out_ready = 1'b1;
                1:       out_ready = ($urandom_range(0, 3) != 0);
                default: out_ready = 1'b0;
            endcase
        end
    end

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Leaves in_valid high so callers can issue back-to-back items
    task automatic send(input int idx, input int tag);
        int  n;
        bit  acc;
        n        = 0;
        in_valid = 1'b1;
        in_index = IDX_W'(idx);
        in_tag   = TAG_W'(tag);
        do begin
            @(negedge clk);
            acc = in_ready;
            @(posedge clk);
            #1;
            n++;
        end while (!acc && n < 200);
        if (!acc) check_eq("send_timeout", int'(acc), 1);
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (sb.size() != 0 && n < 500) begin
            @(posedge clk);
            n++;
        end
        if (sb.size() != 0) check_eq("drain_timeout", sb.size(), 0);
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst      = 1'b1;
        in_valid = 1'b0;
        in_index = '0;
        in_tag   = '0;

        @(negedge clk);
        check_eq("rst_in_ready",  int'(in_ready),  0);
        check_eq("rst_out_valid", int'(out_valid), 0);
        check_eq("rst_sin",       int'(out_sin),   0);
        check_eq("rst_cos",       int'(out_cos),   0);
        check_eq("rst_tag",       int'(out_tag),   0);
        check_eq("rst_err",       int'(out_err),   0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        check_eq("ready_after_rst", int'(in_ready), 1);
        @(posedge clk);
        #1;

        send(0, 8'h11);
        in_valid = 1'b0;
        @(negedge clk);
        check_eq("lat_c1_valid", int'(out_valid), 0);
        @(negedge clk);
        check_eq("lat_c2_valid", int'(out_valid), 1);
        check_eq("idx0_sin", int'($signed(out_sin)), 32);
        check_eq("idx0_cos", int'($signed(out_cos)), 1023);
        check_eq("idx0_err", int'(out_err), 0);
        check_eq("idx0_tag", int'(out_tag), 8'h11);
        @(posedge clk);
        #1;

        send(25, 1);
        send(62, 2);
        send(99, 3);
        in_valid = 1'b0;
        drain();

        send(6, 4);
        in_valid = 1'b0;
        @(negedge clk);
        @(negedge clk);
        check_eq("idx6_sin_trunc", int'($signed(out_sin)),   406);
        check_eq("idx6_cos_trunc", int'($signed(out_cos)),   939);
        check_eq("idx6_sin_round", int'($signed(out_sin_r)), 407);
        check_eq("idx6_cos_round", int'($signed(out_cos_r)), 940);
        @(posedge clk);
        #1;

        send(100, 5);
        send(99, 6);
        send(127, 7);
        in_valid = 1'b0;
        drain();

        or_mode = 1;
        for (int i = 0; i < NBINS; i++) begin
            if ($urandom_range(0, 2) == 0) begin
                in_valid = 1'b0;
                idle(int'($urandom_range(1, 3)));
            end
            send(i, int'($urandom_range(0, 255)));
        end
        for (int i = 0; i < 150; i++) begin
            if ($urandom_range(0, 3) == 0) begin
                in_valid = 1'b0;
                idle(1);
            end
            send(int'($urandom_range(0, 127)), int'($urandom_range(0, 255)));
        end
        in_valid = 1'b0;
        or_mode  = 0;
        drain();

        or_mode = 2;
        idle(1);
        send(10, 8'hA0);
        send(11, 8'hA1);
        in_valid = 1'b0;
        rst = 1'b1;
        sb.delete();
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        check_eq("midrst_out_valid", int'(out_valid), 0);
        check_eq("midrst_sin",       int'(out_sin),   0);
        check_eq("midrst_cos",       int'(out_cos),   0);
        check_eq("midrst_tag",       int'(out_tag),   0);
        check_eq("midrst_err",       int'(out_err),   0);
        check_eq("midrst_in_ready",  int'(in_ready),  1);
        or_mode = 0;
        idle(10);
        send(50, 8'h55);
        in_valid = 1'b0;
        drain();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
